fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Brief   : Sequential instruction prefetch with a credit-limited {instr, pc}
//           FIFO and redirect flush. Define FETCH_BYPASS_EN for same-cycle
//           presentation of a response when the FIFO is empty.
// Rev     : 1.0
// ============================================================================
module fetch_queue #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         INSTR_WIDTH   = 32,
    parameter int                         DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      redirect,
    input  logic [ADDRESS_WIDTH-1:0]  redirect_pc,
    output logic                      mem_req,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [INSTR_WIDTH-1:0]    mem_rdata,
    output logic                      out_valid,
    output logic [INSTR_WIDTH-1:0]    out_instr,
    output logic [ADDRESS_WIDTH-1:0]  out_pc,
    input  logic                      out_ready
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_occ_w = c_cnt_w + 1;
    localparam logic [c_cnt_w-1:0]       c_depth     = c_cnt_w'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] c_word_step = ADDRESS_WIDTH'(4);
    localparam logic [ADDRESS_WIDTH-1:0] c_align     = ~ADDRESS_WIDTH'(3);

    logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
    logic [ADDRESS_WIDTH-1:0] r_resp_pc;
    logic [c_cnt_w-1:0]       r_inflight;
    logic [c_cnt_w-1:0]       r_drop;
    logic [c_cnt_w-1:0]       r_count;
    logic [c_ptr_w-1:0]       r_rd_ptr;
    logic [c_ptr_w-1:0]       r_wr_ptr;
    logic [INSTR_WIDTH-1:0]   r_instr_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_pc_q    [DEPTH];

    logic [c_occ_w-1:0]       w_occ;
    logic [ADDRESS_WIDTH-1:0] w_target;
    logic                     w_grant;
    logic                     w_resp_live;
    logic                     w_bypass;
    logic                     w_push;
    logic                     w_pop;

    assign w_occ    = c_occ_w'(r_inflight) + c_occ_w'(r_count);
    assign w_target = redirect_pc & c_align;
    assign mem_req  = !reset && !redirect && (w_occ < c_occ_w'(DEPTH));
    assign mem_addr = r_fetch_pc;
    assign w_grant  = mem_req && mem_gnt;

    // A response is kept only when nothing stale is still outstanding and no flush is happening.
    assign w_resp_live = mem_rvalid && !redirect && (r_drop == '0);
    assign w_pop       = (r_count != '0) && out_ready && !redirect;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_resp_live && (r_count == '0);
    assign w_push   = w_resp_live && !(w_bypass && out_ready);
`else
    assign w_bypass = 1'b0;
    assign w_push   = w_resp_live;
`endif

    always_comb begin
        out_valid = 1'b0;
        out_instr = '0;
        out_pc    = '0;
        if (r_count != '0) begin
            out_valid = 1'b1;
            out_instr = r_instr_q[r_rd_ptr];
            out_pc    = r_pc_q[r_rd_ptr];
        end else if (w_bypass) begin
            out_valid = 1'b1;
            out_instr = mem_rdata;
            out_pc    = r_resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= r_inflight + c_cnt_w'(w_grant) - c_cnt_w'(mem_rvalid);
            if (redirect) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                // Every still-outstanding response is stale now, including those already
                // marked for dropping, so the new drop count is the post-cycle inflight.
                r_drop     <= r_inflight - c_cnt_w'(mem_rvalid);
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + c_word_step;
                end
                if (mem_rvalid && (r_drop != '0)) begin
                    r_drop <= r_drop - c_cnt_w'(1);
                end
                if (w_resp_live) begin
                    r_resp_pc <= r_resp_pc + c_word_step;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
                r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            end
        end
    end

    // Storage needs no reset; emptiness is tracked by r_count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(w_push && (r_count == c_depth)));
        end
        if (w_push) begin
            r_instr_q[r_wr_ptr] <= mem_rdata;
            r_pc_q[r_wr_ptr]    <= r_resp_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// tb_fetch_queue: directed scenarios against a fixed-latency in-order memory model;
// expected PCs are queued when a current-stream response returns and popped on each output handshake.
`timescale 1ns/1ps
module tb_fetch_queue;
    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   gen;
        logic [31:0]   due;
    } req_t;

    logic          clk = 1'b0;
    logic          reset, redirect, mem_gnt, mem_rvalid, out_ready;
    logic [AW-1:0] redirect_pc;
    logic [IW-1:0] mem_rdata;
    logic          mem_req, out_valid;
    logic [AW-1:0] mem_addr, out_pc;
    logic [IW-1:0] out_instr;

    int            checks   = 0;
    int            failures = 0;
    int            pops     = 0;
    logic [31:0]   cyc = 0, gen = 0, lat = 1, s_cyc = 0;
    logic          gnt_en = 1'b0;
    logic [AW-1:0] exp_fetch = '0;
    req_t          pend[$];
    logic [AW-1:0] sb[$];
    logic          s_out_valid, s_mem_req, first_seen, saw_wrap, met;
    logic [AW-1:0] s_mem_addr, prev_pop_pc, first_pc, hold_addr;
    logic [31:0]   g_cyc, o_cyc;
    int            p0;

    fetch_queue #(
        .ADDRESS_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
        return a ^ 32'hA5C3_0F96;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_gnt(input logic v);
        gnt_en  = v;
        mem_gnt = v;
    endtask

    // One clock cycle: drive, sample at negedge, update model, advance memory at posedge+1.
    task automatic step(input logic redir, input logic [AW-1:0] rpc, input logic rdy);
        req_t          r;
        logic [AW-1:0] e;
        redirect    = redir;
        redirect_pc = rpc;
        out_ready   = rdy;
        @(negedge clk);
        s_cyc       = cyc;
        s_out_valid = out_valid;
        s_mem_req   = mem_req;
        s_mem_addr  = mem_addr;
        if (redir) check("req_in_redirect", 64'(mem_req), 64'(0));
        if (mem_rvalid && pend.size() != 0) begin
            r = pend.pop_front();
            if (r.gen == gen && !redir) sb.push_back(r.addr);
        end
        if (out_valid && out_ready) begin
            pops++;
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL out_unexpected: got pc %0h expected no output", out_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_pc", 64'(out_pc), 64'(e));
                check("out_instr", 64'(out_instr), 64'(instr_of(e)));
                if (!first_seen) begin
                    first_pc   = out_pc;
                    first_seen = 1'b1;
                end
                if (out_pc == '0 && prev_pop_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
                prev_pop_pc = out_pc;
            end
        end
        if (mem_req && mem_gnt) begin
            check("mem_addr", 64'(mem_addr), 64'(exp_fetch));
            pend.push_back(req_t'{addr: exp_fetch, gen: gen, due: cyc + lat});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redir) begin
            gen++;
            exp_fetch = rpc & ~32'h3;
            sb.delete();
        end
        check("occupancy_le_depth", 64'(pend.size() + sb.size() <= DEPTH), 64'(1));
        @(posedge clk);
        #1;
        cyc++;
        mem_gnt = gnt_en;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = instr_of(pend[0].addr);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
    endtask

    task automatic drain();
        set_gnt(1'b0);
        for (int i = 0; i < 40; i++) begin
            if (pend.size() == 0 && sb.size() == 0) break;
            step(1'b0, '0, 1'b1);
        end
        check("drain_done", 64'(pend.size() + sb.size()), 64'(0));
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        first_seen = 1'b0; saw_wrap = 1'b0; prev_pop_pc = '0; first_pc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_instr", 64'(out_instr), 64'(0));
        check("rst_out_pc", 64'(out_pc), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming at latency 1, consumer always ready.
        lat = 1;
        set_gnt(1'b1);
        step(1'b0, '0, 1'b1);
        check("first_req_after_reset", 64'(s_mem_req), 64'(1));
        repeat (3) step(1'b0, '0, 1'b1);
        p0 = pops;
        repeat (12) step(1'b0, '0, 1'b1);
        check("throughput_pops", 64'(pops - p0), 64'(12));

        // Backpressure: buffer fills to DEPTH and issue stops.
        repeat (10) step(1'b0, '0, 1'b0);
        check("bp_mem_req", 64'(s_mem_req), 64'(0));
        check("bp_out_valid", 64'(s_out_valid), 64'(1));
        check("bp_buffered", 64'(sb.size()), 64'(DEPTH));
        check("bp_inflight", 64'(pend.size()), 64'(0));
        repeat (6) step(1'b0, '0, 1'b1);

        // Address wrap through redirect near the top of the address space.
        saw_wrap = 1'b0;
        step(1'b1, 32'hFFFF_FFF4, 1'b1);
        repeat (10) step(1'b0, '0, 1'b1);
        check("addr_wrap_seen", 64'(saw_wrap), 64'(1));

        // Latency 3, three in flight, redirect to an unaligned target.
        drain();
        lat = 3;
        set_gnt(1'b1);
        repeat (3) step(1'b0, '0, 1'b1);
        check("l3_inflight", 64'(pend.size()), 64'(3));
        step(1'b1, 32'h0000_0103, 1'b1);
        first_seen = 1'b0;
        step(1'b0, '0, 1'b1);
        check("redir_req", 64'(s_mem_req), 64'(1));
        check("redir_addr", 64'(s_mem_addr), 64'(32'h100));
        repeat (14) step(1'b0, '0, 1'b1);
        check("redir_first_pc_seen", 64'(first_seen), 64'(1));
        check("redir_first_pc", 64'(first_pc), 64'(32'h100));

        // Redirect coinciding with a response and a consumer handshake on a non-empty FIFO.
        drain();
        lat = 2;
        set_gnt(1'b1);
        met = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_rvalid && pend.size() >= 2 && sb.size() >= 1) begin
                met = 1'b1;
                break;
            end
            step(1'b0, '0, 1'b0);
        end
        check("same_cycle_setup", 64'(met), 64'(1));
        step(1'b1, 32'h0000_0400, 1'b1);
        step(1'b0, '0, 1'b1);
        check("flush_empty_next", 64'(s_out_valid), 64'(0));
        first_seen = 1'b0;
        repeat (10) step(1'b0, '0, 1'b1);
        check("flush_first_pc", 64'(first_pc), 64'(32'h400));

        // Back-to-back redirects with two requests outstanding.
        drain();
        lat = 2;
        set_gnt(1'b1);
        repeat (2) step(1'b0, '0, 1'b1);
        check("b2b_inflight", 64'(pend.size()), 64'(2));
        step(1'b1, 32'h0000_0200, 1'b1);
        step(1'b1, 32'h0000_0300, 1'b1);
        first_seen = 1'b0;
        repeat (12) step(1'b0, '0, 1'b1);
        check("b2b_first_pc_seen", 64'(first_seen), 64'(1));
        check("b2b_first_pc", 64'(first_pc), 64'(32'h300));

        // Grant stall holds the request, then an isolated request measures latency.
        drain();
        hold_addr = exp_fetch;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1);
            check("stall_req", 64'(s_mem_req), 64'(1));
            check("stall_addr", 64'(s_mem_addr), 64'(hold_addr));
            check("stall_out_valid", 64'(s_out_valid), 64'(0));
        end
        lat = 1;
        set_gnt(1'b1);
        step(1'b0, '0, 1'b1);
        g_cyc = s_cyc;
        set_gnt(1'b0);
        o_cyc = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1);
            if (s_out_valid) begin
                o_cyc = s_cyc;
                break;
            end
        end
`ifdef FETCH_BYPASS_EN
        check("latency_bypass", 64'(o_cyc - g_cyc), 64'(1));
`else
        check("latency_fifo", 64'(o_cyc - g_cyc), 64'(2));
`endif

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
